// File: rtl/calc_operand_sequencer.sv
// Panel sequencer for the 4-bit calculator: collects operand A, then operand B,
// writes both into the register file, starts the ALU and flags a valid result.
module calc_operand_sequencer #(
    parameter int DATA_W   = 4,
    parameter int EXEC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        op_sel,
    output logic              write_addr,
    output logic              load,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        alu_op,
    output logic              alu_start,
    output logic              result_valid,
    output logic [2:0]        state_code
);

    typedef enum logic [2:0] {
        WAIT_A = 3'd0,
        LOAD_A = 3'd1,
        WAIT_B = 3'd2,
        LOAD_B = 3'd3,
        EXEC   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    state_t            state;
    state_t            state_nxt;
    logic              enter_q;
    logic              press;
    logic [CNT_W-1:0]  exec_cnt;
    logic [CNT_W-1:0]  exec_cnt_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              write_addr_nxt;
    logic [1:0]        alu_op_nxt;
    logic              load_nxt;
    logic              alu_start_nxt;
    logic              result_valid_nxt;

    // enter_q resets high so a button held through reset never reads as a press.
    assign press      = enter & ~enter_q;
    assign state_code = state;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt      = state;
        exec_cnt_nxt   = exec_cnt;
        wdata_nxt      = wdata;
        write_addr_nxt = write_addr;
        alu_op_nxt     = alu_op;

        if (clear) begin
            state_nxt = WAIT_A;
        end else begin
            case (state)
                WAIT_A: begin
                    if (press) begin
                        wdata_nxt      = data_in;
                        write_addr_nxt = 1'b0;
                        state_nxt      = LOAD_A;
                    end
                end
                LOAD_A: state_nxt = WAIT_B;
                WAIT_B: begin
                    if (press) begin
                        wdata_nxt      = data_in;
                        write_addr_nxt = 1'b1;
                        state_nxt      = LOAD_B;
                    end
                end
                LOAD_B: begin
                    alu_op_nxt   = op_sel;
                    exec_cnt_nxt = CNT_W'(EXEC_LAT - 1);
                    state_nxt    = EXEC;
                end
                EXEC: begin
                    if (exec_cnt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        exec_cnt_nxt = exec_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (press) begin
                        state_nxt = WAIT_A;
                    end
                end
                default: state_nxt = WAIT_A;
            endcase
        end

        // Strobes are decoded from the next state and registered, so they never glitch.
        load_nxt         = (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
        alu_start_nxt    = (state_nxt == EXEC) && (state != EXEC);
        result_valid_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state        <= WAIT_A;
            enter_q      <= 1'b1;
            exec_cnt     <= '0;
            wdata        <= '0;
            write_addr   <= 1'b0;
            alu_op       <= 2'b00;
            load         <= 1'b0;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            enter_q      <= enter;
            exec_cnt     <= exec_cnt_nxt;
            wdata        <= wdata_nxt;
            write_addr   <= write_addr_nxt;
            alu_op       <= alu_op_nxt;
            load         <= load_nxt;
            alu_start    <= alu_start_nxt;
            result_valid <= result_valid_nxt;
        end
    end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer: register-file writes and ALU ops
// are predicted into scoreboard queues and checked when the DUT emits them.
module tb_calc_operand_sequencer;

    logic       clk;
    logic       rst;
    logic       enter;
    logic       clear;
    logic [3:0] data_in;
    logic [1:0] op_sel;
    logic       write_addr;
    logic       load;
    logic [3:0] wdata;
    logic [1:0] alu_op;
    logic       alu_start;
    logic       result_valid;
    logic [2:0] state_code;

    typedef struct packed {
        logic       addr;
        logic [3:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [1:0] op_q[$];
    wr_t        wr_e;
    logic [1:0] op_e;
    int         passed;
    int         total;
    int         load_cnt;
    int         start_cnt;
    int         lc0;
    logic       rv_prev;

    calc_operand_sequencer #(.DATA_W(4), .EXEC_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enter        (enter),
        .clear        (clear),
        .data_in      (data_in),
        .op_sel       (op_sel),
        .write_addr   (write_addr),
        .load         (load),
        .wdata        (wdata),
        .alu_op       (alu_op),
        .alu_start    (alu_start),
        .result_valid (result_valid),
        .state_code   (state_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press with data: returns one cycle after the LOAD cycle.
    task automatic press_val(input logic [3:0] d);
        data_in = d;
        enter   = 1'b1;
        step();
        enter   = 1'b0;
        step();
    endtask

    // Monitor: pops scoreboard entries as writes and results appear.
    always @(negedge clk) begin
        if (rst) begin
            rv_prev <= 1'b0;
        end else begin
            if (load) begin
                load_cnt <= load_cnt + 1;
                check("load_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    wr_e = wr_q.pop_front();
                    check("load_addr", write_addr, wr_e.addr);
                    check("load_wdata", wdata, wr_e.data);
                    check("load_not_start", alu_start, 0);
                end
            end
            if (alu_start) start_cnt <= start_cnt + 1;
            if (result_valid && !rv_prev) begin
                check("result_expected", op_q.size() != 0, 1);
                if (op_q.size() != 0) begin
                    op_e = op_q.pop_front();
                    check("result_alu_op", alu_op, op_e);
                end
            end
            rv_prev <= result_valid;
        end
    end

    initial begin
        passed    = 0;
        total     = 0;
        load_cnt  = 0;
        start_cnt = 0;
        rst       = 1'b1;
        enter     = 1'b0;
        clear     = 1'b0;
        data_in   = 4'h0;
        op_sel    = 2'b00;

        #3;
        check("rst_state", state_code, 0);
        check("rst_load", load, 0);
        check("rst_wdata", wdata, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_start", alu_start, 0);
        check("rst_valid", result_valid, 0);
        check("rst_waddr", write_addr, 0);
        step(2);
        rst = 1'b0;
        step(2);

        // 1: full sequence A=5, B=3, op=01
        data_in = 4'h5;
        op_sel  = 2'b01;
        wr_q.push_back('{addr: 1'b0, data: 4'h5});
        enter = 1'b1;
        step();
        check("t1_load_a_state", state_code, 1);
        check("t1_load_a", load, 1);
        enter = 1'b0;
        step();
        check("t1_wait_b_state", state_code, 2);
        check("t1_load_a_one_cycle", load, 0);
        data_in = 4'h3;
        wr_q.push_back('{addr: 1'b1, data: 4'h3});
        op_q.push_back(2'b01);
        enter = 1'b1;
        step();
        check("t1_load_b_state", state_code, 3);
        enter = 1'b0;
        step();
        check("t1_exec_state", state_code, 4);
        check("t1_start", alu_start, 1);
        check("t1_alu_op", alu_op, 2'b01);
        step();
        check("t1_start_once", alu_start, 0);
        check("t1_valid_early", result_valid, 0);
        step();
        check("t1_done_state", state_code, 5);
        check("t1_valid", result_valid, 1);
        check("t1_start_count", start_cnt, 1);
        enter = 1'b1;
        step();
        check("t1_back_wait_a", state_code, 0);
        check("t1_valid_cleared", result_valid, 0);
        enter = 1'b0;
        step();

        // 2: enter held for 20 cycles gives a single press
        lc0     = load_cnt;
        data_in = 4'h9;
        wr_q.push_back('{addr: 1'b0, data: 4'h9});
        enter = 1'b1;
        step(20);
        check("t2_single_load", load_cnt - lc0, 1);
        check("t2_state_wait_b", state_code, 2);
        enter = 1'b0;
        step();
        check("t2_state_hold", state_code, 2);

        // 3a: clear in WAIT_B
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t3a_state", state_code, 0);
        check("t3a_load", load, 0);
        check("t3a_start", alu_start, 0);
        check("t3a_valid", result_valid, 0);
        check("t3a_wdata_kept", wdata, 4'h9);
        step();

        // 3b: clear in the second EXEC cycle
        wr_q.push_back('{addr: 1'b0, data: 4'h2});
        press_val(4'h2);
        op_sel = 2'b10;
        wr_q.push_back('{addr: 1'b1, data: 4'h7});
        press_val(4'h7);
        check("t3b_exec1_start", alu_start, 1);
        step();
        check("t3b_exec2_state", state_code, 4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t3b_state", state_code, 0);
        check("t3b_load", load, 0);
        check("t3b_start", alu_start, 0);
        check("t3b_valid", result_valid, 0);
        check("t3b_alu_op_kept", alu_op, 2'b10);
        check("t3b_wdata_kept", wdata, 4'h7);
        step();

        // 4: press and clear together in WAIT_A
        lc0     = load_cnt;
        data_in = 4'hF;
        enter   = 1'b1;
        clear   = 1'b1;
        step();
        enter = 1'b0;
        clear = 1'b0;
        check("t4_state", state_code, 0);
        check("t4_load", load, 0);
        check("t4_wdata_kept", wdata, 4'h7);
        step();
        check("t4_state_hold", state_code, 0);
        check("t4_no_load", load_cnt - lc0, 0);

        // 6: press during EXEC ignored, DONE held, press returns to WAIT_A
        wr_q.push_back('{addr: 1'b0, data: 4'h1});
        press_val(4'h1);
        op_sel = 2'b11;
        wr_q.push_back('{addr: 1'b1, data: 4'h4});
        op_q.push_back(2'b11);
        press_val(4'h4);
        enter = 1'b1;
        step();
        check("t6_exec_press_ignored", state_code, 4);
        enter = 1'b0;
        step();
        check("t6_done_state", state_code, 5);
        check("t6_valid", result_valid, 1);
        check("t6_alu_op", alu_op, 2'b11);
        step(3);
        check("t6_done_held", state_code, 5);
        check("t6_valid_held", result_valid, 1);
        enter = 1'b1;
        step();
        check("t6_back_wait_a", state_code, 0);
        check("t6_valid_cleared", result_valid, 0);
        enter = 1'b0;
        step();

        // 5: async reset in LOAD_B, enter high across release
        wr_q.push_back('{addr: 1'b0, data: 4'h6});
        press_val(4'h6);
        data_in = 4'h8;
        op_sel  = 2'b01;
        wr_q.push_back('{addr: 1'b1, data: 4'h8});
        enter = 1'b1;
        step();
        check("t5_load_b_state", state_code, 3);
        check("t5_load_b", load, 1);
        enter = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_state", state_code, 0);
        check("t5_rst_load", load, 0);
        check("t5_rst_waddr", write_addr, 0);
        check("t5_rst_wdata", wdata, 0);
        check("t5_rst_alu_op", alu_op, 0);
        check("t5_rst_start", alu_start, 0);
        check("t5_rst_valid", result_valid, 0);
        enter = 1'b1;
        step(2);
        lc0 = load_cnt;
        rst = 1'b0;
        step(3);
        check("t5_no_press_state", state_code, 0);
        check("t5_no_press_load", load_cnt - lc0, 0);
        enter = 1'b0;
        step();
        check("t5_idle", state_code, 0);

        check("sb_writes_drained", wr_q.size(), 0);
        check("sb_results_drained", op_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
